// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store front-end for a big-endian word-wide data memory.
//            Sub-word stores are read-modify-write; bad accesses get an error response.
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int DM_BYTES = 1024,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       load_data,
    output logic [ADDR_W-1:0] dm_address,
    output logic [31:0]       dm_data_write,
    output logic              dm_mem_write,
    output logic              dm_mem_read,
    input  logic [31:0]       dm_data_read
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] c_MAX_ADDR = ADDR_W'(DM_BYTES - 4);

    state_t            r_state;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_load_data;
    logic [31:0]       r_merge;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic [ADDR_W-1:0] w_aligned;
    logic              w_illegal;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_ext;
    logic [31:0]       w_merged;

    always_comb begin
        w_aligned = {req_addr[ADDR_W-1:2], 2'b00};
        w_illegal = (req_size == 2'b11)
                  | ((req_size == 2'b01) & req_addr[0])
                  | ((req_size == 2'b10) & (|req_addr[1:0]))
                  | (w_aligned > c_MAX_ADDR);
    end

    // Big-endian lanes: byte offset 0 is the most significant byte of the word.
    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'd0:    w_byte = dm_data_read[31:24];
            2'd1:    w_byte = dm_data_read[23:16];
            2'd2:    w_byte = dm_data_read[15:8];
            default: w_byte = dm_data_read[7:0];
        endcase
        w_half = r_addr[1] ? dm_data_read[15:0] : dm_data_read[31:16];
        if (r_size == 2'b00)
            w_load_ext = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        else if (r_size == 2'b01)
            w_load_ext = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        else
            w_load_ext = dm_data_read;
    end

    always_comb begin
        w_merged = r_merge;
        if (r_size == 2'b00) begin
            case (r_addr[1:0])
                2'd0:    w_merged[31:24] = r_wdata[7:0];
                2'd1:    w_merged[23:16] = r_wdata[7:0];
                2'd2:    w_merged[15:8]  = r_wdata[7:0];
                default: w_merged[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merged[15:0] = r_wdata[15:0];
        end else begin
            w_merged[31:16] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_load_data  <= '0;
            r_merge      <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        if (w_illegal)              r_state <= S_ERR;
                        else if (!req_write)        r_state <= S_RD;
                        else if (req_size == 2'b10) r_state <= S_WR;
                        else                        r_state <= S_RMW_RD;
                    end
                end
                S_RD: begin
                    r_load_data  <= w_load_ext;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_WR: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_RMW_RD: begin
                    r_merge <= dm_data_read;
                    r_state <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_ERR: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_err      = r_resp_err;
    assign load_data     = r_load_data;
    assign dm_address    = {r_addr[ADDR_W-1:2], 2'b00};
    assign dm_mem_read   = (r_state == S_RD) || (r_state == S_RMW_RD);
    // Reset must suppress a write the DM would otherwise commit at this edge.
    assign dm_mem_write  = ((r_state == S_WR) || (r_state == S_RMW_WR)) && !reset;
    assign dm_data_write = (r_state == S_RMW_WR) ? w_merged : r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit with a DM model.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] load_data;
    logic [31:0] dm_address;
    logic [31:0] dm_data_write;
    logic        dm_mem_write;
    logic        dm_mem_read;
    logic [31:0] dm_data_read = '0;

    logic [31:0] mem [0:255];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.DM_BYTES(1024), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .load_data    (load_data),
        .dm_address   (dm_address),
        .dm_data_write(dm_data_write),
        .dm_mem_write (dm_mem_write),
        .dm_mem_read  (dm_mem_read),
        .dm_data_read (dm_data_read)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_mem_write) mem[dm_address[9:2]] <= dm_data_write;
    end

    always @(negedge clk) begin
        if (dm_mem_read) begin
            dm_data_read <= mem[dm_address[9:2]];
            rd_cnt       <= rd_cnt + 1;
        end
        if (dm_mem_write) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= dm_address;
            last_wr_data <= dm_data_write;
        end
        if (dm_mem_read && dm_mem_write) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Latency is the index of the resp_valid cycle, the accept cycle being 0.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic err);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_unsigned = u; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
        err = resp_err;
    endtask

    typedef struct {
        logic [1:0]  sz;
        logic [31:0] addr;
    } bad_t;

    initial begin
        int   lat;
        logic err;
        int   r0, w0, idle_resp;
        logic [31:0] ld_before;
        bad_t bad [4];

        bad[0] = '{2'b10, 32'h13};
        bad[1] = '{2'b01, 32'h11};
        bad[2] = '{2'b11, 32'h10};
        bad[3] = '{2'b10, 32'h400};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_strobes", {30'b0, dm_mem_read, dm_mem_write}, 32'd0);
        @(negedge clk); reset = 1'b0;

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, lat, err);
        check("pre_sw10_lat", 32'(lat), 32'd2);
        do_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h1234CDEF, lat, err);
        check("pre_sw3fc_err", {31'b0, err}, 32'd0);

        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, err);
        check("lb11_data", load_data, 32'hFFFFFF99);
        check("lb11_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, err);
        check("lbu11_data", load_data, 32'h00000099);
        check("lbu11_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, err);
        check("lhu12_data", load_data, 32'h0000AABB);
        check("lhu12_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, lat, err);
        check("lbu10_data", load_data, 32'h00000088);

        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, lat, err);
        check("sh12_lat", 32'(lat), 32'd3);
        check("sh12_err", {31'b0, err}, 32'd0);
        check("sh12_reads", 32'(rd_cnt - r0), 32'd1);
        check("sh12_writes", 32'(wr_cnt - w0), 32'd1);
        check("sh12_wdata", last_wr_data, 32'h88991234);
        check("sh12_waddr", last_wr_addr, 32'h10);
        check("sh12_ld_kept", load_data, 32'h00000088);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err);
        check("lw10_after_sh", load_data, 32'h88991234);

        // Store then a load held on the bus, accepted in the store's resp cycle.
        r0 = rd_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_write = 1'b0; req_wdata = 32'h0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("sw20_lat", 32'(lat), 32'd2);
        check("sw20_err", {31'b0, resp_err}, 32'd0);
        check("sw20_no_read", 32'(rd_cnt - r0), 32'd0);
        check("sw20_ready_in_resp", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("lw20_b2b_lat", 32'(lat), 32'd2);
        check("lw20_b2b_data", load_data, 32'hDEADBEEF);

        ld_before = load_data;
        foreach (bad[i]) begin
            r0 = rd_cnt; w0 = wr_cnt;
            do_req(1'b0, bad[i].sz, 1'b0, bad[i].addr, 32'h0, lat, err);
            check($sformatf("bad%0d_err", i), {31'b0, err}, 32'd1);
            check($sformatf("bad%0d_lat", i), 32'(lat), 32'd2);
            check($sformatf("bad%0d_strobes", i), 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
            check($sformatf("bad%0d_ld_kept", i), load_data, ld_before);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0, lat, err);
        check("lh3fe_err", {31'b0, err}, 32'd0);
        check("lh3fe_data", load_data, 32'hFFFFCDEF);

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, lat, err);
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h000000FF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("sb_rst_write_gated", {31'b0, dm_mem_write}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("sb_rst_no_resp", {31'b0, resp_valid}, 32'd0);
        check("sb_rst_load_data", load_data, 32'h0);
        @(posedge clk); #1;
        check("sb_rst_ready_after", {31'b0, req_ready}, 32'd1);
        idle_resp = 0;
        repeat (3) begin
            if (resp_valid) idle_resp++;
            @(posedge clk); #1;
        end
        check("sb_rst_resp_dropped", 32'(idle_resp), 32'd0);
        check("sb_rst_no_write", 32'(wr_cnt - w0), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err);
        check("lw10_after_rst", load_data, 32'h8899AABB);

        check("rd_wr_exclusive", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
